// File: rtl/store_trace_monitor_if.sv
// rtl/store_trace_monitor_if.sv - store bus, drain handshake and status bundle for store_trace_monitor
interface store_trace_monitor_if #(
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    // CPU data-memory write bus
    logic          memwrite;
    logic [31:0]   dataadr;
    logic [31:0]   writedata;

    // drain handshake
    logic          rd_ready;
    logic          rd_valid;
    logic [31:0]   rd_addr;
    logic [31:0]   rd_data;

    // status
    logic [CW-1:0] count;
    logic          overflow;
    logic [7:0]    drop_count;
    logic          done;
    logic [31:0]   done_data;
    logic          timeout;

    // driver side: the CPU bus plus the drain
    modport master (
        output memwrite, dataadr, writedata, rd_ready,
        input  rd_valid, rd_addr, rd_data, count, overflow, drop_count,
               done, done_data, timeout
    );

    // monitor side
    modport slave (
        input  memwrite, dataadr, writedata, rd_ready,
        output rd_valid, rd_addr, rd_data, count, overflow, drop_count,
               done, done_data, timeout
    );
endinterface

// File: rtl/store_trace_monitor.sv
// rtl/store_trace_monitor.sv - store capture FIFO with completion detect and cycle watchdog
module store_trace_monitor #(
    parameter int          DEPTH     = 8,
    parameter logic [31:0] DONE_ADDR = 32'd63,
    parameter int          TIMEOUT   = 1000
) (
    input  logic                   clk,
    input  logic                   reset,
    store_trace_monitor_if.slave   bus
);
    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = PW + 1;
    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [CW-1:0]   FULL    = CW'(DEPTH);

    typedef enum logic [1:0] {S_RUN, S_DONE, S_TIMEOUT} state_e;

    state_e          state_q, state_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;
    logic [7:0]      drop_q, drop_d;
    logic [31:0]     done_data_q, done_data_d;
    logic [31:0]     mem_addr_q [DEPTH];
    logic [31:0]     mem_data_q [DEPTH];

    logic in_run, done_store, push_try, push, pop, full;

    // A completion store in RUN is the only way into DONE; it also gates capture.
    assign done_store = in_run && bus.memwrite && (bus.dataadr == DONE_ADDR);
    assign push_try   = in_run && bus.memwrite;
    assign pop        = (count_q != '0) && bus.rd_ready;
    assign full       = (count_q == FULL);
    // When full, the slot freed by a same-cycle pop is reused by the push.
    assign push       = push_try && (!full || pop);

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_RUN;
        else       state_q <= state_d;
    end

    // FSM next state: completion store beats watchdog expiry in the same cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN: begin
                if (done_store)          state_d = S_DONE;
                else if (wd_q == WD_LAST) state_d = S_TIMEOUT;
            end
            default: state_d = state_q;
        endcase
    end

    // FSM outputs
    always_comb begin
        in_run      = (state_q == S_RUN);
        bus.done    = (state_q == S_DONE);
        bus.timeout = (state_q == S_TIMEOUT);
    end

    // Datapath next-state: pointers, occupancy, drop accounting, watchdog
    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        drop_d      = drop_q;
        done_data_d = done_data_q;
        wd_d        = wd_q;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
        if (push_try && !push) begin
            overflow_d = 1'b1;
            if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
        end
        if (done_store) done_data_d = bus.writedata;
        if (in_run)     wd_d = wd_q + 1'b1;
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            drop_q      <= 8'd0;
            done_data_q <= 32'd0;
            wd_q        <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            drop_q      <= drop_d;
            done_data_q <= done_data_d;
            wd_q        <= wd_d;
        end
    end

    // Entry storage; contents are never read while empty, so no reset is needed
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem_addr_q[wr_ptr_q] <= bus.dataadr;
            mem_data_q[wr_ptr_q] <= bus.writedata;
        end
    end

    // Head presentation, forced to zero while empty
    always_comb begin
        bus.rd_valid   = (count_q != '0);
        bus.rd_addr    = bus.rd_valid ? mem_addr_q[rd_ptr_q] : 32'd0;
        bus.rd_data    = bus.rd_valid ? mem_data_q[rd_ptr_q] : 32'd0;
        bus.count      = count_q;
        bus.overflow   = overflow_q;
        bus.drop_count = drop_q;
        bus.done_data  = done_data_q;
    end
endmodule

// File: tb/tb_store_trace_monitor.sv
// tb/tb_store_trace_monitor.sv - randomized model-checked bench for store_trace_monitor
module tb_store_trace_monitor;
    localparam int          DEPTH     = 8;
    localparam int          TIMEOUT   = 20;
    localparam logic [31:0] DONE_ADDR = 32'd63;

    logic clk = 1'b0;
    logic reset;

    store_trace_monitor_if #(.DEPTH(DEPTH)) bus ();

    store_trace_monitor #(
        .DEPTH(DEPTH), .DONE_ADDR(DONE_ADDR), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: a queue of stores plus run/done/timeout flags
    typedef struct { logic [31:0] a; logic [31:0] d; } ent_t;
    ent_t        mq[$];
    bit          m_ok = 0, m_ovf, m_done, m_to, m_run, m_pop;
    int          m_drops, m_cyc;
    logic [31:0] m_dd;

    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            m_ovf = 0; m_drops = 0; m_done = 0; m_to = 0; m_dd = 0; m_cyc = 0;
            m_ok = 1;
        end else if (m_ok) begin
            m_run = !m_done && !m_to;
            m_pop = (mq.size() > 0) && bus.rd_ready;
            if (m_pop) void'(mq.pop_front());
            if (m_run) begin
                if (bus.memwrite) begin
                    if (mq.size() < DEPTH) mq.push_back('{bus.dataadr, bus.writedata});
                    else begin
                        m_ovf = 1;
                        if (m_drops < 255) m_drops++;
                    end
                end
                if (bus.memwrite && bus.dataadr == DONE_ADDR) begin
                    m_done = 1;
                    m_dd   = bus.writedata;
                end else if (m_cyc == TIMEOUT - 1) begin
                    m_to = 1;
                end
                m_cyc++;
            end
        end
    end

    // compare every cycle, mid-period
    always @(negedge clk) begin
        if (m_ok) begin
            chk("rd_valid",   32'(bus.rd_valid),   32'(mq.size() > 0));
            chk("rd_addr",    bus.rd_addr,         mq.size() > 0 ? mq[0].a : 32'd0);
            chk("rd_data",    bus.rd_data,         mq.size() > 0 ? mq[0].d : 32'd0);
            chk("count",      32'(bus.count),      32'(mq.size()));
            chk("overflow",   32'(bus.overflow),   32'(m_ovf));
            chk("drop_count", 32'(bus.drop_count), 32'(m_drops));
            chk("done",       32'(bus.done),       32'(m_done));
            chk("done_data",  bus.done_data,       m_dd);
            chk("timeout",    32'(bus.timeout),    32'(m_to));
        end
    end

    task automatic cyc(input logic r, input logic mw, input logic [31:0] a,
                       input logic [31:0] d, input logic rdy);
        reset = r; bus.memwrite = mw; bus.dataadr = a; bus.writedata = d; bus.rd_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n, pct;
        logic [31:0] a;

        // reset state and test 1
        cyc(1, 0, 0, 0, 0);
        chk("rst_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_addr", bus.rd_addr, 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_timeout", 32'(bus.timeout), 32'd0);
        cyc(0, 1, 32'd1, 32'h0C0C000A, 0);
        chk("t1_valid", 32'(bus.rd_valid), 32'd1);
        chk("t1_addr", bus.rd_addr, 32'd1);
        chk("t1_data", bus.rd_data, 32'h0C0C000A);
        chk("t1_count", 32'(bus.count), 32'd1);

        // test 2: completion store while draining
        cyc(0, 1, 32'd63, 32'd0, 1);
        chk("t2_done", 32'(bus.done), 32'd1);
        chk("t2_done_data", bus.done_data, 32'd0);
        chk("t2_head", bus.rd_addr, 32'd63);
        cyc(0, 1, 32'd4, 32'd5, 1);
        chk("t2_count", 32'(bus.count), 32'd0);
        chk("t2_valid", 32'(bus.rd_valid), 32'd0);

        // test 3: overflow with drops, then in-order drain
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) cyc(0, 1, 32'(i), $urandom, 0);
        chk("t3_count", 32'(bus.count), 32'd8);
        chk("t3_overflow", 32'(bus.overflow), 32'd1);
        chk("t3_drops", 32'(bus.drop_count), 32'd2);
        for (int i = 0; i < 8; i++) begin
            chk("t3_drain_addr", bus.rd_addr, 32'(i));
            cyc(0, 0, 0, 0, 1);
        end
        chk("t3_empty", 32'(bus.count), 32'd0);

        // test 4: push while full with a simultaneous pop
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 1, 32'(i), 32'(i), 0);
        cyc(0, 1, 32'd100, 32'h77, 1);
        chk("t4_count", 32'(bus.count), 32'd8);
        chk("t4_overflow", 32'(bus.overflow), 32'd0);
        chk("t4_head", bus.rd_addr, 32'd1);

        // test 5: watchdog expiry exactly TIMEOUT edges after reset
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < TIMEOUT - 1; i++) cyc(0, 0, 0, 0, 0);
        chk("t5_before", 32'(bus.timeout), 32'd0);
        cyc(0, 0, 0, 0, 0);
        chk("t5_timeout", 32'(bus.timeout), 32'd1);
        chk("t5_done", 32'(bus.done), 32'd0);
        cyc(0, 1, 32'd63, 32'h1234, 0);
        chk("t5_late_done", 32'(bus.done), 32'd0);
        chk("t5_late_count", 32'(bus.count), 32'd0);

        // test 6: reset mid-operation
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 32'(i + 8), 32'(i), 0);
        cyc(1, 0, 0, 0, 0);
        chk("t6_valid", 32'(bus.rd_valid), 32'd0);
        chk("t6_count", 32'(bus.count), 32'd0);
        chk("t6_overflow", 32'(bus.overflow), 32'd0);
        for (int i = 0; i < TIMEOUT - 1; i++) cyc(0, 0, 0, 0, 0);
        chk("t6_wd_restart", 32'(bus.timeout), 32'd0);
        cyc(0, 0, 0, 0, 0);
        chk("t6_wd_expire", 32'(bus.timeout), 32'd1);

        // randomized episodes
        for (int ep = 0; ep < 40; ep++) begin
            cyc(1, 0, 0, 0, 0);
            n   = $urandom_range(10, 60);
            pct = (ep % 2 == 1) ? 30 : 80;
            for (int i = 0; i < n; i++) begin
                a = ($urandom_range(0, 19) == 0) ? DONE_ADDR : 32'($urandom_range(0, 70));
                if ($urandom_range(0, 1) == 1)
                    cyc($urandom_range(0, 99) < 2, 1, a, $urandom, $urandom_range(0, 99) < pct);
                else
                    cyc($urandom_range(0, 99) < 2, 0, 'x, 'x, $urandom_range(0, 99) < pct);
            end
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
